// File: rtl/dma_pkg.sv
// Shared types and constants for the single-channel word-copy DMA engine.
package dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [1:0] REG_SRC  = 2'd0;
  localparam logic [1:0] REG_DST  = 2'd1;
  localparam logic [1:0] REG_LEN  = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY  = 1;
  localparam int CTRL_DONE  = 2;
  localparam int CTRL_ERR   = 3;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = mask[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dma.sv
// Single-channel word-copy DMA: four-register bus responder plus a registered
// read-then-write bus initiator that copies LEN words from SRC to DST.
//
// state | meaning
// IDLE  | no bus request; waiting for START
// READ  | read request at src_ptr held until ready_in
// WRITE | write of the buffered word to dst_ptr held until ready_in
module dma
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address_in,
  input  logic        sel_in,
  input  logic        read_in,
  output logic [31:0] read_value_out,
  input  logic [3:0]  write_mask_in,
  input  logic [31:0] write_value_in,
  output logic        ready_out,
  output logic [31:0] address_out,
  output logic        read_out,
  output logic        write_out,
  input  logic [31:0] read_value_in,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic        ready_in,
  input  logic        fault_in
);

  state_t               state, next_state;
  logic [31:0]          src_reg, dst_reg;
  logic [LEN_WIDTH-1:0] len_reg;
  logic                 done_reg, err_reg;
  logic [31:0]          src_ptr, dst_ptr, data_buf;
  logic [31:0]          src_nxt, dst_nxt, buf_nxt;
  logic                 len_dec, set_done, set_err;
  logic                 busy, reg_wr, ctrl_wr, start_req;
  logic [1:0]           reg_sel;

  // Read strobe and the unused address bits carry no information for a
  // zero-wait responder with a 16-byte window decoded upstream.
  logic unused_in;
  assign unused_in = &{1'b0, read_in, address_in[31:4], address_in[1:0]};

  assign reg_sel   = address_in[3:2];
  assign busy      = (state != ST_IDLE);
  assign ready_out = sel_in;
  assign reg_wr    = sel_in && (write_mask_in != 4'h0);
  assign ctrl_wr   = reg_wr && (reg_sel == REG_CTRL) && write_mask_in[0];
  assign start_req = ctrl_wr && write_value_in[CTRL_START];

  always_comb begin
    read_value_out = 32'h0;
    if (sel_in) begin
      case (reg_sel)
        REG_SRC: read_value_out = {src_reg[31:2], 2'b00};
        REG_DST: read_value_out = {dst_reg[31:2], 2'b00};
        REG_LEN: read_value_out = 32'(len_reg);
        default: begin
          read_value_out[CTRL_BUSY] = busy;
          read_value_out[CTRL_DONE] = done_reg;
          read_value_out[CTRL_ERR]  = err_reg;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    src_nxt    = src_ptr;
    dst_nxt    = dst_ptr;
    buf_nxt    = data_buf;
    len_dec    = 1'b0;
    set_done   = 1'b0;
    set_err    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_req) begin
          src_nxt = {src_reg[31:2], 2'b00};
          dst_nxt = {dst_reg[31:2], 2'b00};
          if (len_reg != '0) next_state = ST_READ;
          else               set_done   = 1'b1;
        end
      end
      ST_READ: begin
        if (ready_in) begin
          if (fault_in) begin
            set_err    = 1'b1;
            next_state = ST_IDLE;
          end else begin
            buf_nxt    = read_value_in;
            next_state = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (ready_in) begin
          if (fault_in) begin
            set_err    = 1'b1;
            next_state = ST_IDLE;
          end else begin
            src_nxt = src_ptr + 32'd4;
            dst_nxt = dst_ptr + 32'd4;
            len_dec = 1'b1;
            if (len_reg == LEN_WIDTH'(1)) begin
              set_done   = 1'b1;
              next_state = ST_IDLE;
            end else begin
              next_state = ST_READ;
            end
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Register file; programming writes only land while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_reg  <= 32'h0;
      dst_reg  <= 32'h0;
      len_reg  <= '0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      if (reg_wr && !busy) begin
        case (reg_sel)
          REG_SRC: src_reg <= merge_bytes(src_reg, write_value_in, write_mask_in);
          REG_DST: dst_reg <= merge_bytes(dst_reg, write_value_in, write_mask_in);
          REG_LEN: len_reg <= LEN_WIDTH'(merge_bytes(32'(len_reg), write_value_in,
                                                     write_mask_in));
          default: ;
        endcase
      end
      if (len_dec) len_reg <= len_reg - LEN_WIDTH'(1);
      if (start_req && !busy) begin
        done_reg <= set_done;
        err_reg  <= 1'b0;
      end else begin
        done_reg <= (done_reg && !(ctrl_wr && write_value_in[CTRL_DONE])) || set_done;
        err_reg  <= (err_reg && !(ctrl_wr && write_value_in[CTRL_ERR])) || set_err;
      end
    end
  end

  // Initiator outputs are registered from the next-state view so a request
  // appears the cycle after START and holds steady until its ready_in edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr         <= 32'h0;
      dst_ptr         <= 32'h0;
      data_buf        <= 32'h0;
      read_out        <= 1'b0;
      write_out       <= 1'b0;
      write_mask_out  <= 4'h0;
      write_value_out <= 32'h0;
      address_out     <= 32'h0;
    end else begin
      src_ptr         <= src_nxt;
      dst_ptr         <= dst_nxt;
      data_buf        <= buf_nxt;
      read_out        <= (next_state == ST_READ);
      write_out       <= (next_state == ST_WRITE);
      write_mask_out  <= (next_state == ST_WRITE) ? 4'hF : 4'h0;
      write_value_out <= (next_state == ST_WRITE) ? buf_nxt : 32'h0;
      case (next_state)
        ST_READ:  address_out <= src_nxt;
        ST_WRITE: address_out <= dst_nxt;
        default:  address_out <= 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_dma.sv
// Directed bench for dma: pattern-ROM/write-RAM memory model with
// programmable wait states and a fault window above 4 KiB.
module tb_dma;

  localparam logic [31:0] A_SRC  = 32'h0004_0000;
  localparam logic [31:0] A_DST  = 32'h0004_0004;
  localparam logic [31:0] A_LEN  = 32'h0004_0008;
  localparam logic [31:0] A_CTRL = 32'h0004_000C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address_in = '0;
  logic        sel_in = 1'b0;
  logic        read_in = 1'b0;
  logic [31:0] read_value_out;
  logic [3:0]  write_mask_in = '0;
  logic [31:0] write_value_in = '0;
  logic        ready_out;
  logic [31:0] address_out;
  logic        read_out;
  logic        write_out;
  logic [31:0] read_value_in;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic        ready_in;
  logic        fault_in;

  int pass_cnt = 0;
  int total_cnt = 0;

  dma #(.LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .address_in(address_in), .sel_in(sel_in),
    .read_in(read_in), .read_value_out(read_value_out),
    .write_mask_in(write_mask_in), .write_value_in(write_value_in),
    .ready_out(ready_out), .address_out(address_out), .read_out(read_out),
    .write_out(write_out), .read_value_in(read_value_in),
    .write_mask_out(write_mask_out), .write_value_out(write_value_out),
    .ready_in(ready_in), .fault_in(fault_in)
  );

  always #5 clk = ~clk;

  // Memory model: reads return C0DE_xxxx where xxxx is the low address half.
  logic [31:0] wmem [0:1023];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  int          wr_acks = 0;
  int          req_cycles = 0;
  int          stab_err = 0;
  logic        held = 1'b0;
  logic [31:0] p_addr = '0, p_wv = '0;
  logic        p_rd = 1'b0, p_wr = 1'b0;
  logic        mapped;

  assign mapped        = (address_out[31:12] == 20'h0);
  assign ready_in      = (read_out || write_out) && (wait_cnt == wait_cfg);
  assign fault_in      = ready_in && !mapped;
  assign read_value_in = {16'hC0DE, address_out[15:0]};

  always @(posedge clk) begin
    if (ready_in || !(read_out || write_out)) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (write_out && ready_in && mapped) begin
      wmem[address_out[11:2]] <= write_value_out;
      wr_acks <= wr_acks + 1;
    end
    if (read_out || write_out) req_cycles <= req_cycles + 1;
    if (held && (read_out || write_out) &&
        (address_out != p_addr || read_out != p_rd || write_out != p_wr ||
         write_value_out != p_wv))
      stab_err <= stab_err + 1;
    held   <= (read_out || write_out) && !ready_in;
    p_addr <= address_out;
    p_rd   <= read_out;
    p_wr   <= write_out;
    p_wv   <= write_value_out;
  end

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m);
    @(negedge clk);
    sel_in = 1'b1; address_in = a; write_value_in = d; write_mask_in = m;
    @(posedge clk); #1;
    sel_in = 1'b0; address_in = '0; write_value_in = '0; write_mask_in = '0;
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] d);
    sel_in = 1'b1; read_in = 1'b1; address_in = a;
    #1;
    d = read_value_out;
    sel_in = 1'b0; read_in = 1'b0; address_in = '0;
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    total_cnt++;
    if ({read_out, write_out, write_mask_out} !== 6'h0)
      $display("FAIL reset_req: got %b want 0", {read_out, write_out, write_mask_out});
    else pass_cnt++;
    total_cnt++;
    if (address_out !== 32'h0 || write_value_out !== 32'h0)
      $display("FAIL reset_bus: addr %h wv %h want 0", address_out, write_value_out);
    else pass_cnt++;
    total_cnt++;
    if (ready_out !== 1'b0 || read_value_out !== 32'h0)
      $display("FAIL reset_resp: ready %b rdata %h want 0", ready_out, read_value_out);
    else pass_cnt++;
    reg_read(A_SRC, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL reset_src: got %h want 0", v); else pass_cnt++;
    reg_read(A_LEN, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL reset_len: got %h want 0", v); else pass_cnt++;
    reg_read(A_CTRL, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL reset_ctrl: got %h want 0", v); else pass_cnt++;
  endtask

  task automatic test_zero_wait;
    logic [31:0] v;
    reg_write(A_SRC, 32'h100, 4'hF);
    reg_write(A_DST, 32'h200, 4'hF);
    reg_write(A_LEN, 32'd4, 4'hF);
    reg_write(A_CTRL, 32'h1, 4'hF);
    total_cnt++;
    if (read_out !== 1'b1 || write_out !== 1'b0 || address_out !== 32'h100)
      $display("FAIL zw_first_read: rd %b wr %b addr %h want 1 0 00000100",
               read_out, write_out, address_out);
    else pass_cnt++;
    reg_read(A_CTRL, v);
    total_cnt++;
    if (v !== 32'h2) $display("FAIL zw_busy: got %h want 2", v); else pass_cnt++;
    repeat (7) @(posedge clk);
    #1;
    reg_read(A_CTRL, v);
    total_cnt++;
    if (v !== 32'h2) $display("FAIL zw_not_done_c8: got %h want 2", v); else pass_cnt++;
    reg_read(A_LEN, v);
    total_cnt++;
    if (v !== 32'd1) $display("FAIL zw_live_len: got %0d want 1", v); else pass_cnt++;
    @(posedge clk); #1;
    reg_read(A_CTRL, v);
    total_cnt++;
    if (v !== 32'h4) $display("FAIL zw_done_c9: got %h want 4", v); else pass_cnt++;
    reg_read(A_LEN, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL zw_len0: got %h want 0", v); else pass_cnt++;
    reg_read(A_SRC, v);
    total_cnt++;
    if (v !== 32'h100) $display("FAIL zw_src_kept: got %h want 100", v); else pass_cnt++;
    total_cnt++;
    if (wmem[128] !== 32'hC0DE0100 || wmem[129] !== 32'hC0DE0104 ||
        wmem[130] !== 32'hC0DE0108 || wmem[131] !== 32'hC0DE010C)
      $display("FAIL zw_data: got %h %h %h %h want C0DE0100..C0DE010C",
               wmem[128], wmem[129], wmem[130], wmem[131]);
    else pass_cnt++;
    total_cnt++;
    if (read_out !== 1'b0 || write_out !== 1'b0)
      $display("FAIL zw_idle_req: rd %b wr %b want 0 0", read_out, write_out);
    else pass_cnt++;
  endtask

  task automatic test_w1c_mask;
    logic [31:0] v;
    reg_write(A_CTRL, 32'h4, 4'h1);
    reg_read(A_CTRL, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL w1c_done: got %h want 0", v); else pass_cnt++;
    reg_write(A_SRC, 32'hFFFF_FFFF, 4'b0011);
    reg_read(A_SRC, v);
    total_cnt++;
    if (v !== 32'h0000_FFFC) $display("FAIL byte_mask: got %h want 0000fffc", v);
    else pass_cnt++;
  endtask

  task automatic test_wait_states;
    logic [31:0] v;
    int s0;
    wait_cfg = 3;
    s0 = stab_err;
    reg_write(A_SRC, 32'h140, 4'hF);
    reg_write(A_DST, 32'h300, 4'hF);
    reg_write(A_LEN, 32'd2, 4'hF);
    reg_write(A_CTRL, 32'h1, 4'hF);
    repeat (15) @(posedge clk);
    #1;
    reg_read(A_CTRL, v);
    total_cnt++;
    if (v !== 32'h2) $display("FAIL ws_not_done_15: got %h want 2", v); else pass_cnt++;
    @(posedge clk); #1;
    reg_read(A_CTRL, v);
    total_cnt++;
    if (v !== 32'h4) $display("FAIL ws_done_16: got %h want 4", v); else pass_cnt++;
    total_cnt++;
    if (wmem[192] !== 32'hC0DE0140 || wmem[193] !== 32'hC0DE0144)
      $display("FAIL ws_data: got %h %h want c0de0140 c0de0144", wmem[192], wmem[193]);
    else pass_cnt++;
    total_cnt++;
    if (stab_err - s0 !== 0) $display("FAIL ws_stable: got %0d changes want 0", stab_err - s0);
    else pass_cnt++;
    wait_cfg = 0;
  endtask

  task automatic test_fault;
    logic [31:0] v;
    int w0;
    reg_write(A_SRC, 32'h0005_0000, 4'hF);
    reg_write(A_DST, 32'h400, 4'hF);
    reg_write(A_LEN, 32'd2, 4'hF);
    w0 = wr_acks;
    reg_write(A_CTRL, 32'h1, 4'hF);
    @(posedge clk); #1;
    reg_read(A_CTRL, v);
    total_cnt++;
    if (v !== 32'h8) $display("FAIL fault_ctrl: got %h want 8", v); else pass_cnt++;
    reg_read(A_LEN, v);
    total_cnt++;
    if (v !== 32'd2) $display("FAIL fault_len: got %0d want 2", v); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (wr_acks - w0 !== 0 || write_out !== 1'b0)
      $display("FAIL fault_no_write: got %0d writes wr %b want 0", wr_acks - w0, write_out);
    else pass_cnt++;
  endtask

  task automatic test_len_zero;
    logic [31:0] v;
    int r0;
    reg_write(A_LEN, 32'd0, 4'hF);
    r0 = req_cycles;
    reg_write(A_CTRL, 32'h1, 4'hF);
    reg_read(A_CTRL, v);
    total_cnt++;
    if (v !== 32'h4) $display("FAIL len0_done: got %h want 4", v); else pass_cnt++;
    repeat (4) @(posedge clk);
    #1;
    total_cnt++;
    if (req_cycles - r0 !== 0) $display("FAIL len0_no_req: got %0d req cycles want 0",
                                        req_cycles - r0);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore;
    logic [31:0] v;
    int w0;
    bit done;
    reg_write(A_SRC, 32'h180, 4'hF);
    reg_write(A_DST, 32'h500, 4'hF);
    reg_write(A_LEN, 32'd3, 4'hF);
    w0 = wr_acks;
    reg_write(A_CTRL, 32'h1, 4'hF);
    reg_write(A_SRC, 32'hDEAD_0000, 4'hF);
    reg_write(A_CTRL, 32'h1, 4'hF);
    done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(posedge clk); #1;
      reg_read(A_CTRL, v);
      if (v[2]) done = 1'b1;
    end
    total_cnt++;
    if (!done) $display("FAIL busy_timeout: ctrl %h want done within 50 cycles", v);
    else pass_cnt++;
    reg_read(A_SRC, v);
    total_cnt++;
    if (v !== 32'h180) $display("FAIL busy_src_kept: got %h want 180", v); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (wr_acks - w0 !== 3) $display("FAIL busy_writes: got %0d want 3", wr_acks - w0);
    else pass_cnt++;
    total_cnt++;
    if (wmem[320] !== 32'hC0DE0180 || wmem[321] !== 32'hC0DE0184 ||
        wmem[322] !== 32'hC0DE0188)
      $display("FAIL busy_data: got %h %h %h want c0de0180 c0de0184 c0de0188",
               wmem[320], wmem[321], wmem[322]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    int r0;
    reg_write(A_SRC, 32'h100, 4'hF);
    reg_write(A_DST, 32'h600, 4'hF);
    reg_write(A_LEN, 32'd4, 4'hF);
    reg_write(A_CTRL, 32'h1, 4'hF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    total_cnt++;
    if ({read_out, write_out, write_mask_out} !== 6'h0 || address_out !== 32'h0 ||
        write_value_out !== 32'h0)
      $display("FAIL rst_mid_out: rd %b wr %b mask %h addr %h wv %h want all 0",
               read_out, write_out, write_mask_out, address_out, write_value_out);
    else pass_cnt++;
    reg_read(A_CTRL, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL rst_mid_ctrl: got %h want 0", v); else pass_cnt++;
    reg_read(A_DST, v);
    total_cnt++;
    if (v !== 32'h0) $display("FAIL rst_mid_dst: got %h want 0", v); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    r0 = req_cycles;
    repeat (10) @(posedge clk);
    #1;
    total_cnt++;
    if (req_cycles - r0 !== 0) $display("FAIL rst_mid_no_req: got %0d want 0",
                                        req_cycles - r0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_w1c_mask();
    test_wait_states();
    test_fault();
    test_len_zero();
    test_busy_ignore();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
